// File: rtl/bp_ctrl.sv
// Branch direction predictor control: gshare index/GHR management plus a
// two-port resolved-branch update FIFO that streams writes into the BHT.
module bp_ctrl #(
    parameter int width = 10,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_br,
    input  logic [31:0]      f_pc,
    input  logic             bht_pred,
    output logic             bht_read,
    output logic [width-1:0] bht_r_idx,
    output logic             pred_taken,
    output logic [width-1:0] pred_idx,
    output logic [width-1:0] pred_ghr,
    input  logic             res0_valid,
    input  logic [width-1:0] res0_idx,
    input  logic             res0_pred,
    input  logic             res0_mispred,
    input  logic [width-1:0] res0_ghr,
    output logic             res0_ready,
    input  logic             res1_valid,
    input  logic [width-1:0] res1_idx,
    input  logic             res1_pred,
    input  logic             res1_mispred,
    input  logic [width-1:0] res1_ghr,
    output logic             res1_ready,
    output logic             bht_load,
    output logic [width-1:0] bht_w_idx,
    output logic             bht_taken,
    output logic             bht_correct
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam int EW = width + 2;

    logic [width-1:0] ghr, ghr_next;
    logic [EW-1:0]    mem [depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_next, free;
    logic             rr, rr_next;
    logic             acc0, acc1, deq;
    logic [1:0]       enq_n;
    logic             w0_en, w1_en;
    logic [EW-1:0]    w0_data, w1_data, ent0, ent1, head;
    logic             unused_bits;

    assign unused_bits = ^{f_pc[31:width+2], f_pc[1:0], res0_ghr[width-1], res1_ghr[width-1]};

    assign bht_read   = f_br;
    assign bht_r_idx  = f_pc[width+1:2] ^ ghr;
    assign pred_taken = bht_pred & f_br;
    assign pred_idx   = bht_r_idx;
    assign pred_ghr   = ghr;

    // Readiness uses registered occupancy only; the head leaving this cycle is not credited.
    assign free       = CW'(depth) - count;
    assign res0_ready = (free >= CW'(2)) || ((free == CW'(1)) && (!rr || !res1_valid));
    assign res1_ready = (free >= CW'(2)) || ((free == CW'(1)) && (rr || !res0_valid));
    assign acc0       = res0_valid & res0_ready;
    assign acc1       = res1_valid & res1_ready;
    assign ent0       = {res0_idx, res0_pred, res0_mispred};
    assign ent1       = {res1_idx, res1_pred, res1_mispred};

    assign head        = mem[rd_ptr];
    assign bht_load    = (count != '0);
    assign deq         = bht_load;
    assign bht_w_idx   = head[EW-1:2];
    assign bht_taken   = head[1];
    assign bht_correct = ~head[0];

    always_comb begin
        w0_en    = 1'b0;
        w1_en    = 1'b0;
        w0_data  = ent0;
        w1_data  = ent1;
        enq_n    = 2'd0;
        rr_next  = rr;
        ghr_next = ghr;
        if (acc0 && acc1) begin
            w0_en   = 1'b1;
            w1_en   = 1'b1;
            enq_n   = 2'd2;
            rr_next = ~rr;
            if (rr) begin
                w0_data = ent1;
                w1_data = ent0;
            end
        end else if (acc0) begin
            w0_en   = 1'b1;
            enq_n   = 2'd1;
            rr_next = 1'b1;
        end else if (acc1) begin
            w0_en   = 1'b1;
            w0_data = ent1;
            enq_n   = 2'd1;
            rr_next = 1'b0;
        end
        // Repair beats speculation, and port 0 (older) beats port 1.
        if (f_br)
            ghr_next = {ghr[width-2:0], bht_pred};
        if (acc0 && res0_mispred)
            ghr_next = {res0_ghr[width-2:0], ~res0_pred};
        else if (acc1 && res1_mispred)
            ghr_next = {res1_ghr[width-2:0], ~res1_pred};
        count_next = count + CW'(enq_n) - CW'(deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr    <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr     <= 1'b0;
        end else begin
            ghr    <= ghr_next;
            count  <= count_next;
            wr_ptr <= wr_ptr + AW'(enq_n);
            rd_ptr <= rd_ptr + AW'(deq);
            rr     <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w0_en)
            mem[wr_ptr] <= w0_data;
        if (w1_en)
            mem[wr_ptr + AW'(1)] <= w1_data;
    end
endmodule

// File: tb/tb_bp_ctrl.sv
// Self-checking bench for bp_ctrl: directed corner cases then random traffic,
// compared against a queue-based model of the predictor and update FIFO.
module tb_bp_ctrl;
    localparam int W = 10;
    localparam int D = 4;
    localparam int MASK = (1 << W) - 1;

    logic          clk, rst;
    logic          f_br, bht_pred;
    logic [31:0]   f_pc;
    logic          bht_read, pred_taken;
    logic [W-1:0]  bht_r_idx, pred_idx, pred_ghr;
    logic          res0_valid, res0_pred, res0_mispred, res0_ready;
    logic [W-1:0]  res0_idx, res0_ghr;
    logic          res1_valid, res1_pred, res1_mispred, res1_ready;
    logic [W-1:0]  res1_idx, res1_ghr;
    logic          bht_load, bht_taken, bht_correct;
    logic [W-1:0]  bht_w_idx;

    bp_ctrl #(.width(W), .depth(D)) dut (
        .clk(clk), .rst(rst),
        .f_br(f_br), .f_pc(f_pc), .bht_pred(bht_pred),
        .bht_read(bht_read), .bht_r_idx(bht_r_idx),
        .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .res0_valid(res0_valid), .res0_idx(res0_idx), .res0_pred(res0_pred),
        .res0_mispred(res0_mispred), .res0_ghr(res0_ghr), .res0_ready(res0_ready),
        .res1_valid(res1_valid), .res1_idx(res1_idx), .res1_pred(res1_pred),
        .res1_mispred(res1_mispred), .res1_ghr(res1_ghr), .res1_ready(res1_ready),
        .bht_load(bht_load), .bht_w_idx(bht_w_idx),
        .bht_taken(bht_taken), .bht_correct(bht_correct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int pred;
        int mis;
    } ent_t;

    ent_t m_q[$];
    int   m_ghr;
    int   m_rr;
    int   total = 0;
    int   bad = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int n);
        int free;
        bit other_valid;
        free = D - m_q.size();
        other_valid = (n == 0) ? res1_valid : res0_valid;
        return (free >= 2) || (free == 1 && (m_rr == n || !other_valid));
    endfunction

    task automatic clearInputs();
        f_br = 0; f_pc = '0; bht_pred = 0;
        res0_valid = 0; res0_idx = '0; res0_pred = 0; res0_mispred = 0; res0_ghr = '0;
        res1_valid = 0; res1_idx = '0; res1_pred = 0; res1_mispred = 0; res1_ghr = '0;
    endtask

    // Inputs are already driven; let them settle and compare combinational outputs with the model.
    task automatic applyStimulus();
        int exp_idx;
        #1;
        exp_idx = ((f_pc >> 2) & MASK) ^ m_ghr;
        checkOutput("bht_read", 32'(bht_read), 32'(f_br));
        checkOutput("bht_r_idx", 32'(bht_r_idx), exp_idx);
        checkOutput("pred_taken", 32'(pred_taken), 32'(bht_pred & f_br));
        checkOutput("pred_idx", 32'(pred_idx), exp_idx);
        checkOutput("pred_ghr", 32'(pred_ghr), m_ghr);
        checkOutput("res0_ready", 32'(res0_ready), 32'(exp_ready(0)));
        checkOutput("res1_ready", 32'(res1_ready), 32'(exp_ready(1)));
        checkOutput("bht_load", 32'(bht_load), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            checkOutput("bht_w_idx", 32'(bht_w_idx), m_q[0].idx);
            checkOutput("bht_taken", 32'(bht_taken), m_q[0].pred);
            checkOutput("bht_correct", 32'(bht_correct), 32'(m_q[0].mis == 0));
        end
    endtask

    // Advance the model by one clock edge, then move to the next falling edge.
    task automatic step();
        bit a0, a1;
        ent_t e0, e1;
        a0 = res0_valid && exp_ready(0);
        a1 = res1_valid && exp_ready(1);
        e0 = '{int'(res0_idx), int'(res0_pred), int'(res0_mispred)};
        e1 = '{int'(res1_idx), int'(res1_pred), int'(res1_mispred)};
        if (f_br)
            m_ghr = ((m_ghr << 1) | int'(bht_pred)) & MASK;
        if (a0 && res0_mispred)
            m_ghr = ((int'(res0_ghr) << 1) | (1 - int'(res0_pred))) & MASK;
        else if (a1 && res1_mispred)
            m_ghr = ((int'(res1_ghr) << 1) | (1 - int'(res1_pred))) & MASK;
        if (m_q.size() > 0)
            void'(m_q.pop_front());
        if (a0 && a1) begin
            if (m_rr == 0) begin m_q.push_back(e0); m_q.push_back(e1); end
            else begin m_q.push_back(e1); m_q.push_back(e0); end
            m_rr = 1 - m_rr;
        end else if (a0) begin
            m_q.push_back(e0);
            m_rr = 1;
        end else if (a1) begin
            m_q.push_back(e1);
            m_rr = 0;
        end
        @(negedge clk);
    endtask

    task automatic bothValid(input int i0, input int i1);
        clearInputs();
        res0_valid = 1; res0_idx = W'(i0);
        res1_valid = 1; res1_idx = W'(i1);
    endtask

    initial begin
        clearInputs();
        rst = 1;
        m_q.delete(); m_ghr = 0; m_rr = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_load", 32'(bht_load), 0);
        checkOutput("reset_rdy0", 32'(res0_ready), 1);
        checkOutput("reset_rdy1", 32'(res1_ready), 1);
        checkOutput("reset_ghr", 32'(pred_ghr), 0);
        rst = 0;
        @(negedge clk);

        // Empty FIFO, both ports valid, rr=0
        bothValid(10'h010, 10'h020);
        applyStimulus();
        checkOutput("both_rdy0", 32'(res0_ready), 1);
        checkOutput("both_rdy1", 32'(res1_ready), 1);
        step();
        bothValid(10'h030, 10'h040);
        applyStimulus();
        checkOutput("order_first", 32'(bht_w_idx), 32'h010);
        step();
        bothValid(10'h050, 10'h060);
        applyStimulus();
        checkOutput("order_second", 32'(bht_w_idx), 32'h020);
        step();
        // Now count=3 and rr=1
        bothValid(10'h070, 10'h080);
        applyStimulus();
        checkOutput("free1_rdy1", 32'(res1_ready), 1);
        checkOutput("free1_rdy0", 32'(res0_ready), 0);
        step();
        bothValid(10'h090, 10'h0A0);
        applyStimulus();
        checkOutput("free1_rr_rdy0", 32'(res0_ready), 1);
        checkOutput("free1_rr_rdy1", 32'(res1_ready), 0);
        step();
        clearInputs();
        repeat (4) begin applyStimulus(); step(); end

        // Force ghr to 0x005 through a repair, then predict from it
        clearInputs();
        res0_valid = 1; res0_mispred = 1; res0_pred = 0; res0_ghr = 10'h002;
        applyStimulus(); step();
        clearInputs();
        f_br = 1; f_pc = 32'h0000_0010; bht_pred = 1;
        applyStimulus();
        checkOutput("gshare_idx", 32'(bht_r_idx), 32'h001);
        step();
        clearInputs();
        applyStimulus();
        checkOutput("spec_ghr", 32'(pred_ghr), 32'h00B);
        step();
        repeat (2) begin applyStimulus(); step(); end

        // Repair overrides a concurrent speculative shift
        clearInputs();
        res0_valid = 1; res0_mispred = 1; res0_pred = 1; res0_ghr = 10'h3FF;
        f_br = 1; bht_pred = 1; f_pc = 32'h1234_5678;
        applyStimulus(); step();
        clearInputs();
        applyStimulus();
        checkOutput("repair_ghr", 32'(pred_ghr), 32'h3FE);
        step();
        repeat (2) begin applyStimulus(); step(); end

        // Head encoding for a mispredicted not-taken branch
        clearInputs();
        res0_valid = 1; res0_idx = 10'h155; res0_pred = 0; res0_mispred = 1; res0_ghr = 10'h0F0;
        applyStimulus(); step();
        clearInputs();
        applyStimulus();
        checkOutput("enc_load", 32'(bht_load), 1);
        checkOutput("enc_idx", 32'(bht_w_idx), 32'h155);
        checkOutput("enc_taken", 32'(bht_taken), 0);
        checkOutput("enc_correct", 32'(bht_correct), 0);
        step();

        // Fill to three entries, then reset mid-operation
        repeat (2) begin
            bothValid(10'h111, 10'h222);
            f_br = 1; bht_pred = 1;
            applyStimulus(); step();
        end
        clearInputs();
        applyStimulus();
        rst = 1;
        #1;
        checkOutput("midrst_load", 32'(bht_load), 0);
        checkOutput("midrst_ghr", 32'(pred_ghr), 0);
        checkOutput("midrst_rdy0", 32'(res0_ready), 1);
        checkOutput("midrst_rdy1", 32'(res1_ready), 1);
        m_q.delete(); m_ghr = 0; m_rr = 0;
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            applyStimulus();
            checkOutput("post_rst_noload", 32'(bht_load), 0);
            step();
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            f_br         = ($urandom_range(0, 1) == 1);
            f_pc         = $urandom;
            bht_pred     = ($urandom_range(0, 1) == 1);
            res0_valid   = ($urandom_range(0, 9) < 6);
            res0_idx     = W'($urandom);
            res0_pred    = ($urandom_range(0, 1) == 1);
            res0_mispred = ($urandom_range(0, 3) == 0);
            res0_ghr     = W'($urandom);
            res1_valid   = ($urandom_range(0, 9) < 6);
            res1_idx     = W'($urandom);
            res1_pred    = ($urandom_range(0, 1) == 1);
            res1_mispred = ($urandom_range(0, 3) == 0);
            res1_ghr     = W'($urandom);
            applyStimulus();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
